hamming_link_sequencer: RTL

//  Sequences 64-bit PRESENT cipher blocks through the Hamming(21,16) SEC datapath for a framed serial link.
//  TX side: splits an accepted block into NWORDS 16-bit words, encodes each with hamming_enco and streams codewords out.
//  RX side: accepts codewords, corrects each with hamming_deco, reassembles the block and presents it downstream.

---
 rtl/hamming_link_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hamming_link_sequencer.sv
// Streams 64-bit cipher blocks over a framed serial link as Hamming(21,16) SEC codewords.
// The TX half encodes and serialises blocks; the RX half corrects and reassembles them. The two halves run independently.
module hamming_link_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_in_valid,
  output logic                 tx_in_ready,
  input  logic [16*NWORDS-1:0] tx_in_block,
  output logic                 tx_cw_valid,
  input  logic                 tx_cw_ready,
  output logic [20:0]          tx_cw,
  output logic                 tx_cw_last,
  input  logic                 rx_cw_valid,
  output logic                 rx_cw_ready,
  input  logic [20:0]          rx_cw,
  input  logic                 rx_cw_last,
  output logic                 rx_out_valid,
  input  logic                 rx_out_ready,
  output logic [16*NWORDS-1:0] rx_out_block,
  output logic                 rx_frame_err
);

  localparam int BW = 16 * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic {T_IDLE, T_SEND} tx_state_e;
  typedef enum logic {R_COLLECT, R_HOLD} rx_state_e;

  // Codeword position p (1..21) lives at bit [21-p]. Parity sits at power-of-two positions.
  // Message bit 1 (msg[15]) fills the lowest data position.
  function automatic logic [20:0] enco(input logic [15:0] msg);
    logic [21:1] c;
    logic [20:0] cw;
    logic        par;
    int          d;
    c  = '0;
    cw = '0;
    d  = 15;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = msg[d];
        d--;
      end
    end
    for (int j = 0; j < 5; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 21; p++) begin
        if ((((p >> j) & 1) == 1) && (p != (1 << j))) par = par ^ c[p];
      end
      c[1 << j] = par;
    end
    for (int p = 1; p <= 21; p++) cw[21 - p] = c[p];
    return cw;
  endfunction

  function automatic logic [15:0] deco(input logic [20:0] cw);
    logic [21:1] c;
    logic [4:0]  syn;
    logic [15:0] msg;
    int          d;
    syn = '0;
    msg = '0;
    d   = 15;
    for (int p = 1; p <= 21; p++) c[p] = cw[21 - p];
    for (int p = 1; p <= 21; p++) begin
      if (c[p]) syn = syn ^ 5'(p);
    end
    // Syndromes above 21 can only arise from multi-bit errors; pass those through uncorrected.
    if ((syn != 5'd0) && (syn <= 5'd21)) c[syn] = ~c[syn];
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        msg[d] = c[p];
        d--;
      end
    end
    return msg;
  endfunction

  tx_state_e       tx_state_q, tx_state_d;
  logic [IW-1:0]   tx_idx_q, tx_idx_d;
  logic [BW-1:0]   tx_block_q, tx_block_d;
  logic [15:0]     tx_word;

  rx_state_e       rx_state_q, rx_state_d;
  logic [IW-1:0]   rx_idx_q, rx_idx_d;
  logic [BW-1:0]   rx_block_q, rx_block_d;
  logic            rx_frame_err_q, rx_frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q     <= T_IDLE;
      tx_idx_q       <= '0;
      tx_block_q     <= '0;
      rx_state_q     <= R_COLLECT;
      rx_idx_q       <= '0;
      rx_block_q     <= '0;
      rx_frame_err_q <= 1'b0;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_idx_q       <= tx_idx_d;
      tx_block_q     <= tx_block_d;
      rx_state_q     <= rx_state_d;
      rx_idx_q       <= rx_idx_d;
      rx_block_q     <= rx_block_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  // The codeword is derived from held state, so it stays stable while the channel stalls.
  assign tx_word     = tx_block_q[BW - 1 - 16 * int'(tx_idx_q) -: 16];
  assign tx_in_ready = (tx_state_q == T_IDLE);
  assign tx_cw_valid = (tx_state_q == T_SEND);
  assign tx_cw_last  = (tx_state_q == T_SEND) && (tx_idx_q == LAST_IDX);
  assign tx_cw       = (tx_state_q == T_SEND) ? enco(tx_word) : '0;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_block_d = tx_block_q;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_in_valid) begin
          tx_block_d = tx_in_block;
          tx_idx_d   = '0;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (tx_cw_ready) begin
          if (tx_idx_q == LAST_IDX) tx_state_d = T_IDLE;
          else                      tx_idx_d   = tx_idx_q + IW'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  assign rx_cw_ready  = (rx_state_q == R_COLLECT);
  assign rx_out_valid = (rx_state_q == R_HOLD);
  assign rx_out_block = rx_block_q;
  assign rx_frame_err = rx_frame_err_q;

  // A last marker and the final slot must coincide; otherwise the partial frame is dropped.
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_idx_d       = rx_idx_q;
    rx_block_d     = rx_block_q;
    rx_frame_err_d = 1'b0;
    case (rx_state_q)
      R_COLLECT: begin
        if (rx_cw_valid) begin
          rx_block_d[BW - 1 - 16 * int'(rx_idx_q) -: 16] = deco(rx_cw);
          if (rx_cw_last && (rx_idx_q == LAST_IDX)) begin
            rx_state_d = R_HOLD;
          end else if (rx_cw_last || (rx_idx_q == LAST_IDX)) begin
            rx_frame_err_d = 1'b1;
            rx_idx_d       = '0;
          end else begin
            rx_idx_d = rx_idx_q + IW'(1);
          end
        end
      end
      R_HOLD: begin
        if (rx_out_ready) begin
          rx_state_d = R_COLLECT;
          rx_idx_d   = '0;
        end
      end
      default: rx_state_d = R_COLLECT;
    endcase
  end

endmodule
